muldiv_out: RTL
===============

MULDIV_OUT -- requirements
Module: muldiv_out

Interface
REQ-001 SHALL have parameter SHORTCUT_EN, default 1: when 1, trivial-operand results bypass the core; when 0, every operation waits for core_valid.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: launches an operation; sampled only in IDLE.
REQ-005 SHALL have port muldiv_sel, input, 1 bit: 0 = multiply, 1 = divide/remainder.
REQ-006 SHALL have port op_mul, input, 2 bits: 00 = MUL, 01 = MULH, 10 = MULHSU, 11 = MULHU.
REQ-007 SHALL have port op_div0, input, 1 bit: 1 = unsigned divide (DIVU/REMU).
REQ-008 SHALL have port op_rem, input, 1 bit: 1 = return remainder, 0 = return quotient.
REQ-009 SHALL have ports in_A and in_B, input, 32 bits each: original operands, sampled with start.
REQ-010 SHALL have port AB_status, input, 6 bits: {Bm1, B1, B0, Am1, A1, A0} operand flags, sampled with start.
REQ-011 SHALL have port core_valid, input, 1 bit: core result strobe.
REQ-012 SHALL have ports core_prod (input, 64 bits), core_quot (input, 32 bits) and core_rem (input, 32 bits): unsigned magnitudes from the core.
REQ-013 SHALL have port result, output, 32 bits: final signed-corrected result.
REQ-014 SHALL have port result_valid, output, 1 bit: result held valid.
REQ-015 SHALL have port result_ready, input, 1 bit: consumer accepts result.
REQ-016 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, WAIT, FIX_LO, FIX_HI and DONE.
REQ-018 On start in IDLE, SHALL register the operation context: op fields, sA = in_A[31], sB = in_B[31], AB_status, in_A, in_B.
REQ-019 IDLE + start SHALL go to DONE when SHORTCUT_EN and a shortcut applies; otherwise it SHALL go to WAIT.
REQ-020 Shortcuts SHALL be: mul with A0|B0 -> 0; div with B0 -> quot 0xFFFFFFFF, rem in_A; div with B1 -> quot in_A, rem 0; signed div with in_A = 0x80000000 and Bm1 -> quot 0x80000000, rem 0.
REQ-021 WAIT SHALL sample core_valid; when it is high, capture core_prod/core_quot/core_rem, then go to FIX_LO if negation is needed, else DONE.
REQ-022 The mul negate condition SHALL be: op 00/01 -> sA^sB; 10 -> sA; 11 -> never.
REQ-023 For div, quotient negate SHALL be !op_div0 & (sA^sB) and remainder negate SHALL be !op_div0 & sA.
REQ-024 FIX_LO SHALL two's-complement the low word (product[31:0] or quotient) and register the carry.
REQ-025 FIX_HI SHALL invert product[63:32] and add the registered carry (mul), or independently two's-complement the remainder (div).
REQ-026 FIX_LO SHALL always go to FIX_HI, and FIX_HI SHALL always go to DONE.
REQ-027 Result select SHALL be: MUL -> low word; MULH/MULHSU/MULHU -> high word; DIV/DIVU -> quotient; REM/REMU -> remainder.
REQ-028 result SHALL be registered on the edge entering DONE, and result_valid SHALL be 1 exactly in DONE.
REQ-029 DONE SHALL hold result stable until result_ready is high, then go to IDLE.
REQ-030 Latency SHALL be: shortcut, 1 cycle after the start edge; core path without fix, 1 cycle after the core_valid edge; core path with fix, 3 cycles after the core_valid edge.
REQ-031 core_valid outside WAIT SHALL be ignored, including core_valid coincident with start.
REQ-032 start outside IDLE SHALL be ignored; start is not accepted in the same cycle as a DONE handshake.

Reset
REQ-033 rst SHALL force IDLE with result = 0, result_valid = 0, busy = 0, carry = 0 and context registers = 0.
REQ-034 rst SHALL take priority over start, core_valid and result_ready in any state.
REQ-035 rst mid-operation SHALL discard the pending operation; a later core_valid SHALL be ignored.

Verification
REQ-036 Bench SHALL cover: MUL in_A = 0xFFFFFFFD, in_B = 5, core_prod = 15 -> result 0xFFFFFFF1, result_valid 3 cycles after core_valid.
REQ-037 Bench SHALL cover: MULH 0x80000000 x 0x80000000, core_prod = 0x4000000000000000 -> result 0x40000000 with 1-cycle latency, no FIX states.
REQ-038 Bench SHALL cover: DIV 7 / 0 -> result 0xFFFFFFFF one cycle after start with no core_valid; REM 7 / 0 -> result 7.
REQ-039 Bench SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000; REM of the same operands -> result 0; DIVU of the same operands -> routed to WAIT.
REQ-040 Bench SHALL cover: REM 0xFFFFFFF9 % 2, core_quot = 3, core_rem = 1 -> result 0xFFFFFFFF; DIV of the same operands -> result 0xFFFFFFFD.
REQ-041 Bench SHALL cover: result_ready held low for 5 cycles -> result and result_valid stable; rst asserted in FIX_HI -> IDLE, result_valid 0 next cycle, later core_valid ignored.

Source files
------------

// File: rtl/muldiv_out_if.sv
// Operand, core-result and result handshake bundle for the multiply/divide output stage.
interface muldiv_out_if;
  logic        start;
  logic        muldiv_sel;
  logic [1:0]  op_mul;
  logic        op_div0;
  logic        op_rem;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic [5:0]  AB_status;
  logic        core_valid;
  logic [63:0] core_prod;
  logic [31:0] core_quot;
  logic [31:0] core_rem;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  modport master (
    output start, muldiv_sel, op_mul, op_div0, op_rem, in_A, in_B, AB_status,
    output core_valid, core_prod, core_quot, core_rem, result_ready,
    input  result, result_valid, busy
  );

  modport slave (
    input  start, muldiv_sel, op_mul, op_div0, op_rem, in_A, in_B, AB_status,
    input  core_valid, core_prod, core_quot, core_rem, result_ready,
    output result, result_valid, busy
  );
endinterface

// File: rtl/muldiv_out.sv
// Sign correction and result sequencing for an unsigned mul/div core: shortcuts,
// two-step 64-bit negation, quotient/remainder fix-up and a held result handshake.
module muldiv_out #(
  parameter bit SHORTCUT_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  muldiv_out_if.slave bus
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {IDLE, WAIT, FIX_LO, FIX_HI, DONE} state_t;

  state_t state, state_nxt;

  // operation context captured with start
  logic              is_div_q;
  logic [1:0]        op_mul_q;
  logic              op_div0_q;
  logic              op_rem_q;
  logic              sa_q;
  logic              sb_q;
  logic [5:0]        ab_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  logic [2*DATA_W-1:0] prod_p0;
  logic [DATA_W-1:0]   quot_p0;
  logic [DATA_W-1:0]   rem_p0;
  logic                carry_p1;
  logic [DATA_W-1:0]   result_q;

  logic              sc_hit;
  logic [DATA_W-1:0] sc_val;
  logic              mul_neg, quot_neg, rem_neg, fix_need;
  logic [DATA_W-1:0] hi_fix, rem_fix;
  logic              unused_ctx;

  function automatic logic [DATA_W-1:0] twos_neg(input logic signed [DATA_W-1:0] v);
    return -v;
  endfunction

  function automatic logic [DATA_W:0] neg_with_carry(input logic [DATA_W-1:0] v);
    return {1'b0, ~v} + {{DATA_W{1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] sel_result(
    input logic                is_div,
    input logic [1:0]          op_mul,
    input logic                op_rem,
    input logic [2*DATA_W-1:0] prod,
    input logic [DATA_W-1:0]   quot,
    input logic [DATA_W-1:0]   rem
  );
    if (is_div) return op_rem ? rem : quot;
    return (op_mul == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
  endfunction

  // AB_status = {Bm1, B1, B0, Am1, A1, A0}
  always_comb begin
    sc_hit = 1'b0;
    sc_val = '0;
    if (!bus.muldiv_sel) begin
      sc_hit = bus.AB_status[0] | bus.AB_status[3];
    end else if (bus.AB_status[3]) begin
      sc_hit = 1'b1;
      sc_val = bus.op_rem ? bus.in_A : {DATA_W{1'b1}};
    end else if (bus.AB_status[4]) begin
      sc_hit = 1'b1;
      sc_val = bus.op_rem ? '0 : bus.in_A;
    end else if (!bus.op_div0 && bus.AB_status[5] && bus.in_A == 32'h8000_0000) begin
      sc_hit = 1'b1;
      sc_val = bus.op_rem ? '0 : 32'h8000_0000;
    end
    sc_hit = sc_hit & SHORTCUT_EN;
  end

  always_comb begin
    mul_neg = 1'b0;
    case (op_mul_q)
      2'b00, 2'b01: mul_neg = sa_q ^ sb_q;
      2'b10:        mul_neg = sa_q;
      default:      mul_neg = 1'b0;
    endcase
    quot_neg = !op_div0_q & (sa_q ^ sb_q);
    rem_neg  = !op_div0_q & sa_q;
    fix_need = is_div_q ? (quot_neg | rem_neg) : mul_neg;
    hi_fix   = ~prod_p0[2*DATA_W-1:DATA_W] + {{(DATA_W-1){1'b0}}, carry_p1};
    rem_fix  = rem_neg ? twos_neg(rem_p0) : rem_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = sc_hit ? DONE : WAIT;
      WAIT:    if (bus.core_valid) state_nxt = fix_need ? FIX_LO : DONE;
      FIX_LO:  state_nxt = FIX_HI;
      FIX_HI:  state_nxt = DONE;
      DONE:    if (bus.result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q  <= 1'b0;
      op_mul_q  <= '0;
      op_div0_q <= 1'b0;
      op_rem_q  <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      ab_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_p0   <= '0;
      quot_p0   <= '0;
      rem_p0    <= '0;
      carry_p1  <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state)
        // p0: context capture, or shortcut result straight into DONE
        IDLE: if (bus.start) begin
          is_div_q  <= bus.muldiv_sel;
          op_mul_q  <= bus.op_mul;
          op_div0_q <= bus.op_div0;
          op_rem_q  <= bus.op_rem;
          sa_q      <= bus.in_A[DATA_W-1];
          sb_q      <= bus.in_B[DATA_W-1];
          ab_q      <= bus.AB_status;
          a_q       <= bus.in_A;
          b_q       <= bus.in_B;
          if (sc_hit) result_q <= sc_val;
        end
        // p0: core magnitudes; unsigned-clean results finish here
        WAIT: if (bus.core_valid) begin
          prod_p0 <= bus.core_prod;
          quot_p0 <= bus.core_quot;
          rem_p0  <= bus.core_rem;
          if (!fix_need)
            result_q <= sel_result(is_div_q, op_mul_q, op_rem_q,
                                   bus.core_prod, bus.core_quot, bus.core_rem);
        end
        // p1: low word negation, carry kept for the high word
        FIX_LO: begin
          if (is_div_q) begin
            if (quot_neg) quot_p0 <= twos_neg(quot_p0);
          end else begin
            {carry_p1, prod_p0[DATA_W-1:0]} <= neg_with_carry(prod_p0[DATA_W-1:0]);
          end
        end
        // p2: high word / remainder fix and final select
        FIX_HI: begin
          if (!is_div_q) prod_p0[2*DATA_W-1:DATA_W] <= hi_fix;
          else           rem_p0 <= rem_fix;
          result_q <= sel_result(is_div_q, op_mul_q, op_rem_q,
                                 {hi_fix, prod_p0[DATA_W-1:0]}, quot_p0, rem_fix);
        end
        default: ;
      endcase
    end
  end

  assign unused_ctx       = ^{a_q, b_q, ab_q};
  assign bus.result       = result_q;
  assign bus.result_valid = (state == DONE);
  assign bus.busy         = (state != IDLE);

endmodule
